// File: rtl/ddr3_emu_pkg.sv
// rtl/ddr3_emu_pkg.sv - shared types and constants for the DDR3 AXI slave emulator
//
// Purpose: FSM state encoding and beat geometry shared by the emulator files.
// Ports:   none (package).
package ddr3_emu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AW_ACK,
        WR,
        AR_ACK,
        RD_PREP,
        RD
    } state_t;

    // One 128-bit beat spans 8 DQ-word address units, so the beat index starts at addr bit 3.
    localparam int BEAT_SHIFT = 3;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

    localparam int STRB_W = strb_width(128);

endpackage

// File: rtl/ddr3_axi_slave_emu_if.sv
// rtl/ddr3_axi_slave_emu_if.sv - DDR3 IP user AXI port signal bundle
//
// Purpose: groups the AW/W/AR/R signals of the DDR3 IP user port.
//          No wvalid, no rready, no B channel; the slave generates the write last flag.
// Modports:
//   master - drives addresses, lengths, valids, write data/strobes; receives readies and read data
//   slave  - the mirror image, used by ddr3_axi_slave_emu
interface ddr3_axi_slave_emu_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int LEN_W  = 4
);
    logic [ADDR_W-1:0]   axi_awaddr;
    logic [LEN_W-1:0]    axi_awlen;
    logic                axi_awvalid;
    logic                axi_awready;
    logic [DATA_W-1:0]   axi_wdata;
    logic [DATA_W/8-1:0] axi_wstrb;
    logic                axi_wready;
    logic                axi_wusero_last;
    logic [ADDR_W-1:0]   axi_araddr;
    logic [LEN_W-1:0]    axi_arlen;
    logic                axi_arvalid;
    logic                axi_arready;
    logic [DATA_W-1:0]   axi_rdata;
    logic                axi_rvalid;
    logic                axi_rlast;

    modport master (
        output axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_wstrb,
               axi_araddr, axi_arlen, axi_arvalid,
        input  axi_awready, axi_wready, axi_wusero_last,
               axi_arready, axi_rdata, axi_rvalid, axi_rlast
    );

    modport slave (
        input  axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_wstrb,
               axi_araddr, axi_arlen, axi_arvalid,
        output axi_awready, axi_wready, axi_wusero_last,
               axi_arready, axi_rdata, axi_rvalid, axi_rlast
    );
endinterface

// File: rtl/ddr3_emu_ram.sv
// rtl/ddr3_emu_ram.sv - simple dual-port beat RAM with byte enables
//
// Purpose: backing store for the emulator; contents survive reset.
// Ports:
//   clk, rst        clock, async active-high reset (read register only)
//   we/waddr/wdata/wstrb   write port, byte-enable masked
//   re/raddr/rdata  read port, one-cycle registered latency; rdata holds when re=0
module ddr3_emu_ram #(
    parameter int AW = 10,
    parameter int DW = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Only the output register is reset so rdata reads 0 out of reset; the array is not cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/ddr3_axi_slave_emu.sv
// rtl/ddr3_axi_slave_emu.sv - on-chip RAM responder standing in for the DDR3 IP user AXI port
//
// Purpose: answers the AXI master exactly like the DDR3 IP user port, backed by ddr3_emu_ram.
// Ports:
//   clk            single clock (ui_clk domain of the master)
//   rst            asynchronous active-high reset
//   ddr_init_done  sticky, rises INIT_CYCLES cycles after reset release
//   protocol_err   sticky, a valid was dropped during its ready pulse
//   axi            slave modport of ddr3_axi_slave_emu_if (AW, W, AR, R)
module ddr3_axi_slave_emu
    import ddr3_emu_pkg::*;
#(
    parameter int ADDR_W      = 28,
    parameter int DATA_W      = 128,
    parameter int LEN_W       = 4,
    parameter int MEM_AW      = 10,
    parameter int INIT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ddr_init_done,
    output logic                 protocol_err,
    ddr3_axi_slave_emu_if.slave  axi
);
    localparam int INIT_W = $clog2(INIT_CYCLES) + 1;
    localparam int PTR_HI = MEM_AW + BEAT_SHIFT - 1;

    state_t            state, state_n;
    logic [MEM_AW-1:0] ptr, ptr_n;
    logic [LEN_W-1:0]  cnt, cnt_n;
    logic              prio, prio_n;   // 0: write wins a tie, 1: read wins
    logic              perr_n;
    logic [INIT_W-1:0] init_cnt;

    logic awready_q, wready_q, wlast_q;
    logic arready_q, rvalid_q, rlast_q;

    // Address bits outside the beat index are ignored; the RAM aliases beyond its depth.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi.axi_awaddr[ADDR_W-1:PTR_HI+1], axi.axi_awaddr[BEAT_SHIFT-1:0],
                                axi.axi_araddr[ADDR_W-1:PTR_HI+1], axi.axi_araddr[BEAT_SHIFT-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt      <= '0;
            ddr_init_done <= 1'b0;
        end else if (!ddr_init_done) begin
            if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
                ddr_init_done <= 1'b1;
            end else begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        prio_n  = prio;
        perr_n  = protocol_err;
        unique case (state)
            IDLE: begin
                if (ddr_init_done) begin
                    if (axi.axi_awvalid && (!axi.axi_arvalid || !prio)) begin
                        state_n = AW_ACK;
                        prio_n  = ~prio;
                    end else if (axi.axi_arvalid) begin
                        state_n = AR_ACK;
                        prio_n  = ~prio;
                    end
                end
            end
            AW_ACK: begin
                if (axi.axi_awvalid) begin
                    ptr_n   = axi.axi_awaddr[PTR_HI:BEAT_SHIFT];
                    cnt_n   = axi.axi_awlen;
                    state_n = WR;
                end else begin
                    perr_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            WR: begin
                ptr_n = ptr + 1'b1;
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            AR_ACK: begin
                if (axi.axi_arvalid) begin
                    ptr_n   = axi.axi_araddr[PTR_HI:BEAT_SHIFT];
                    cnt_n   = axi.axi_arlen;
                    state_n = RD_PREP;
                end else begin
                    perr_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            // The RAM read of ptr issues here; ptr then always runs one beat ahead of rdata.
            RD_PREP: begin
                ptr_n   = ptr + 1'b1;
                state_n = RD;
            end
            RD: begin
                ptr_n = ptr + 1'b1;
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each flag lines up with its state cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            prio         <= 1'b0;
            protocol_err <= 1'b0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            wlast_q      <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            cnt          <= cnt_n;
            prio         <= prio_n;
            protocol_err <= perr_n;
            awready_q    <= (state_n == AW_ACK);
            wready_q     <= (state_n == WR);
            wlast_q      <= (state_n == WR) && (cnt_n == '0);
            arready_q    <= (state_n == AR_ACK);
            rvalid_q     <= (state_n == RD);
            rlast_q      <= (state_n == RD) && (cnt_n == '0);
        end
    end

    ddr3_emu_ram #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wready_q),
        .waddr (ptr),
        .wdata (axi.axi_wdata),
        .wstrb (axi.axi_wstrb),
        .re    ((state == RD_PREP) || (state == RD)),
        .raddr (ptr),
        .rdata (axi.axi_rdata)
    );

    assign axi.axi_awready     = awready_q;
    assign axi.axi_wready      = wready_q;
    assign axi.axi_wusero_last = wlast_q;
    assign axi.axi_arready     = arready_q;
    assign axi.axi_rvalid      = rvalid_q;
    assign axi.axi_rlast       = rlast_q;
endmodule

// File: tb/tb_ddr3_axi_slave_emu.sv
// tb/tb_ddr3_axi_slave_emu.sv - self-checking bench for ddr3_axi_slave_emu
module tb_ddr3_axi_slave_emu;
    import ddr3_emu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ddr_init_done;
    logic protocol_err;

    ddr3_axi_slave_emu_if #(.ADDR_W(28), .DATA_W(128), .LEN_W(4)) axi ();

    ddr3_axi_slave_emu #(
        .ADDR_W(28), .DATA_W(128), .LEN_W(4), .MEM_AW(10), .INIT_CYCLES(64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ddr_init_done (ddr_init_done),
        .protocol_err  (protocol_err),
        .axi           (axi)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: beat-addressed memory of 1024 entries, a tie-break bit, write data queue.
    logic [127:0] model_mem [0:1023];
    bit           prio_m = 1'b0;
    logic [127:0] wq [$];
    logic [15:0]  sq [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_assert++;
        n_fail++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    function automatic int beat_of(input logic [27:0] a);
        return (int'(a) / 8) % 1024;
    endfunction

    task automatic model_write(input int p, input logic [127:0] d, input logic [15:0] s);
        for (int b = 0; b < 16; b++) begin
            if (s[b]) model_mem[p % 1024][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic fill_random(input int n, input bit full_strb);
        wq.delete();
        sq.delete();
        for (int i = 0; i < n; i++) begin
            wq.push_back({$urandom, $urandom, $urandom, $urandom});
            sq.push_back(full_strb ? 16'hFFFF : 16'($urandom));
        end
    endtask

    // Drives one write and/or one read request and follows both to completion.
    task automatic run_ops(input bit do_w, input logic [27:0] waddr, input int wlen,
                           input bit do_r, input logic [27:0] raddr, input int rlen,
                           input int rst_beat);
        int wb = 0;
        int rb = 0;
        int cyc = 0;
        int aw_cyc = 0;
        int ar_cyc = 0;
        bit aw_pend = do_w;
        bit ar_pend = do_r;
        bit aw_drop = 1'b0;
        bit ar_drop = 1'b0;
        bit w_done = !do_w;
        bit r_done = !do_r;
        logic [1:0] exp_g;
        @(negedge clk);
        axi.axi_awaddr  = waddr;
        axi.axi_awlen   = 4'(wlen);
        axi.axi_awvalid = do_w;
        axi.axi_araddr  = raddr;
        axi.axi_arlen   = 4'(rlen);
        axi.axi_arvalid = do_r;
        while (!(w_done && r_done)) begin
            @(negedge clk);
            cyc++;
            if (cyc > 200) begin
                fail_now("burst_timeout");
                axi.axi_awvalid = 1'b0;
                axi.axi_arvalid = 1'b0;
                return;
            end
            if (aw_drop) begin axi.axi_awvalid = 1'b0; aw_drop = 1'b0; end
            if (ar_drop) begin axi.axi_arvalid = 1'b0; ar_drop = 1'b0; end
            if (axi.axi_awready || axi.axi_arready) begin
                if (aw_pend && ar_pend) exp_g = prio_m ? 2'b01 : 2'b10;
                else if (aw_pend)       exp_g = 2'b10;
                else if (ar_pend)       exp_g = 2'b01;
                else                    exp_g = 2'b00;
                check("grant_aw_ar", {axi.axi_awready, axi.axi_arready}, exp_g);
                prio_m = ~prio_m;
                if (axi.axi_awready) begin aw_pend = 1'b0; aw_drop = 1'b1; aw_cyc = cyc; end
                if (axi.axi_arready) begin ar_pend = 1'b0; ar_drop = 1'b1; ar_cyc = cyc; end
            end
            if (axi.axi_wready) begin
                if (wb == 0) check("w_latency", cyc - aw_cyc, 1);
                check("wusero_last", axi.axi_wusero_last, wb == wlen);
                if (wb < wq.size()) begin
                    axi.axi_wdata = wq[wb];
                    axi.axi_wstrb = sq[wb];
                    model_write(beat_of(waddr) + wb, wq[wb], sq[wb]);
                end
                wb++;
                if (wb == wlen + 1) w_done = 1'b1;
            end
            if (axi.axi_rvalid) begin
                if (rb == 0) check("r_latency", cyc - ar_cyc, 2);
                check("rdata", axi.axi_rdata, model_mem[(beat_of(raddr) + rb) % 1024]);
                check("rlast", axi.axi_rlast, rb == rlen);
                rb++;
                if (rb == rst_beat) begin
                    rst = 1'b1;
                    #1;
                    check("rst_rvalid", axi.axi_rvalid, 0);
                    check("rst_rlast", axi.axi_rlast, 0);
                    check("rst_state", dut.state, IDLE);
                    check("rst_init_done", ddr_init_done, 0);
                    prio_m = 1'b0;
                    axi.axi_awvalid = 1'b0;
                    axi.axi_arvalid = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
                if (rb == rlen + 1) r_done = 1'b1;
            end
        end
        @(negedge clk);
        check("burst_end_quiet",
              {axi.axi_awready, axi.axi_wready, axi.axi_arready, axi.axi_rvalid}, 4'b0000);
    endtask

    task automatic wait_init();
        int n = 0;
        while (!ddr_init_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("init_cycles", n, 64);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        axi.axi_awaddr  = '0;
        axi.axi_awlen   = '0;
        axi.axi_awvalid = 1'b0;
        axi.axi_wdata   = '0;
        axi.axi_wstrb   = '0;
        axi.axi_araddr  = '0;
        axi.axi_arlen   = '0;
        axi.axi_arvalid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 1: reset state, init timer, awvalid ignored during init
        check("reset_outputs",
              {ddr_init_done, protocol_err, axi.axi_awready, axi.axi_wready, axi.axi_wusero_last,
               axi.axi_arready, axi.axi_rvalid, axi.axi_rlast}, 8'h00);
        check("reset_rdata", axi.axi_rdata, 0);
        check("reset_state", dut.state, IDLE);
        axi.axi_awvalid = 1'b1;
        rst = 1'b0;
        #1;
        for (int i = 0; i <= 66; i++) begin
            if (i > 0) @(negedge clk);
            check("init_done", ddr_init_done, i >= 64);
            if (i < 60) check("awready_in_init", axi.axi_awready, 0);
            if (i == 59) axi.axi_awvalid = 1'b0;
        end
        check("perr_after_init", protocol_err, 0);

        // 2: 4-beat write of A0..A3 at 0x40, then read it back
        wq.delete();
        sq.delete();
        for (int i = 0; i < 4; i++) begin
            wq.push_back({16{8'(8'hA0 + i)}});
            sq.push_back(16'hFFFF);
        end
        run_ops(1, 28'h40, 3, 0, 28'h0, 0, -1);
        run_ops(0, 28'h0, 0, 1, 28'h40, 3, -1);
        check("beat8_a0", model_mem[8], {16{8'hA0}});

        // 3: partial strobe over an all-ones pattern
        wq.delete();
        sq.delete();
        for (int i = 0; i < 2; i++) begin wq.push_back({128{1'b1}}); sq.push_back(16'hFFFF); end
        run_ops(1, 28'h80, 1, 0, 28'h0, 0, -1);
        fill_random(2, 1'b0);
        sq[0] = 16'h00FF;
        sq[1] = 16'h00FF;
        run_ops(1, 28'h80, 1, 0, 28'h0, 0, -1);
        run_ops(0, 28'h0, 0, 1, 28'h80, 1, -1);

        // 5: pointer wrap at beat 1022; read back through an aliased address with low bits set
        fill_random(4, 1'b1);
        run_ops(1, 28'h1FF0, 3, 0, 28'h0, 0, -1);
        run_ops(0, 28'h0, 0, 1, 28'h3FF3, 3, -1);
        run_ops(0, 28'h0, 0, 1, 28'h0, 1, -1);

        // random bursts: full write, random-strobe overwrite, read back
        for (int k = 0; k < 6; k++) begin
            logic [27:0] a;
            int l;
            a = 28'($urandom);
            l = int'($urandom_range(0, 15));
            fill_random(l + 1, 1'b1);
            run_ops(1, a, l, 0, 28'h0, 0, -1);
            fill_random(l + 1, 1'b0);
            run_ops(1, a, l, 0, 28'h0, 0, -1);
            run_ops(0, 28'h0, 0, 1, a, l, -1);
        end

        // 6: reset during the second beat of an 8-beat read; RAM contents survive
        fill_random(8, 1'b1);
        run_ops(1, 28'h1000, 7, 0, 28'h0, 0, -1);
        run_ops(0, 28'h0, 0, 1, 28'h1000, 7, 2);
        wait_init();
        run_ops(0, 28'h0, 0, 1, 28'h1000, 7, -1);

        // 4: simultaneous awvalid/arvalid, twice
        for (int k = 0; k < 2; k++) begin
            fill_random(4, 1'b1);
            run_ops(1, 28'h1000 + 28'(k * 64), 3, 1, 28'h1000 + 28'(k * 64), 3, -1);
        end

        // 7: awvalid dropped during the awready pulse
        @(negedge clk);
        axi.axi_awaddr  = 28'h200;
        axi.axi_awlen   = 4'd2;
        axi.axi_awvalid = 1'b1;
        begin
            int n = 0;
            while (!axi.axi_awready && n < 10) begin @(negedge clk); n++; end
            check("perr_grant_seen", axi.axi_awready, 1);
        end
        prio_m = ~prio_m;
        axi.axi_awvalid = 1'b0;
        @(negedge clk);
        check("protocol_err_set", protocol_err, 1);
        check("perr_state_idle", dut.state, IDLE);
        for (int i = 0; i < 4; i++) begin
            check("perr_no_wready", axi.axi_wready, 0);
            @(negedge clk);
        end
        fill_random(2, 1'b1);
        run_ops(1, 28'h300, 1, 0, 28'h0, 0, -1);
        run_ops(0, 28'h0, 0, 1, 28'h300, 1, -1);
        check("protocol_err_sticky", protocol_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
